fft_sample_framer: RTL
======================

Name: fft_sample_framer

Overview:
- Downstream of the 8-bit serial-in shift register that feeds the FFT input path. It counts the serial bit enables and captures each completed 8-bit parallel word.
- Captured words are written into a ping-pong frame buffer of N samples per bank, in bit-reversed address order for a radix-2 DIT FFT.
- Each filled frame is handed to the FFT core through a valid/release handshake.

Parameters:
- WIDTH, 8, sample width in bits; equals the shift register width.
- LOG2N, 3, log2 of frame length; N = 2**LOG2N samples per bank.
- BITREV, 1, 1 = write address is the bit-reversed sample index; 0 = natural order.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; must be the same reset that drives the shift register.
- en  in  1  serial bit enable; the same signal that drives the shift register's en.
- shift_word  in  WIDTH  parallel output of the shift register.
- rd_addr  in  LOG2N  FFT read address within the current read bank.
- rd_data  out  WIDTH  sample at rd_addr in the read bank.
- frame_valid  out  1  read bank holds a complete frame.
- frame_release  in  1  one-cycle pulse from the FFT: read bank consumed.
- word_strobe  out  1  one-cycle pulse on each sample write attempt.
- overrun  out  1  sticky flag: at least one sample was dropped.

Behaviour:
- Reset: bit_cnt=0, samp_idx=0, wb=0, rb=0, full[1:0]=0, capture_pend=0, rd_data=0, frame_valid=0, word_strobe=0, overrun=0. RAM contents are not cleared and are don't-care after reset.
- Bit counting: bit_cnt (log2 WIDTH bits) increments on every cycle with en=1 and wraps WIDTH-1 -> 0.
  - On the cycle where en=1 and bit_cnt=WIDTH-1, set capture_pend for the next cycle only.
- Capture timing: the shift register updates on that same edge, so shift_word holds the complete word one cycle later.
  - The capture write occurs in the capture_pend cycle; word_strobe=1 in that cycle.
  - en=1 in the capture_pend cycle is legal. The word is sampled before that edge's shift, and bit_cnt counts the new bit normally.
- Bit order: the first serial bit received ends in bit 0 (LSB); the last bit received is the MSB.
- Write: if full[wb]=0, write shift_word to mem[wb][addr], where addr = bitrev(samp_idx) when BITREV=1, else samp_idx. Then samp_idx++.
  - When samp_idx wraps N-1 -> 0: set full[wb] and toggle wb.
- Drop: if full[wb]=1 at capture, the sample is not written, samp_idx is unchanged and overrun is set (sticky until reset). word_strobe still pulses.
- Read side: frame_valid = full[rb], a registered-state combinational output.
  - rd_data <= mem[rb][rd_addr] each cycle (1-cycle read latency, no enable). rd_data is don't-care while frame_valid=0.
- Release: frame_release=1 with frame_valid=1 clears full[rb] and toggles rb at the edge. Release while frame_valid=0 is ignored.
- Simultaneous release and capture into the bank being released: the capture sees the pre-edge full value and is dropped (overrun). No same-cycle bypass.
- Simultaneous release of bank rb and completion of bank wb (different banks): both take effect. frame_valid rises the next cycle if the new rb is full.
- Reset mid-frame: the partial frame is discarded. Alignment restarts at bit 0, so the upstream shift register must be reset in the same cycle.
- Width rules: samp_idx is LOG2N bits. bitrev reverses all LOG2N bits. No arithmetic on data.

Decomposition:
- Shared package fft_pkg:
  - constants FFT_WIDTH=8 and FFT_LOG2N=3;
  - function bitrev(idx, LOG2N);
  - typedef for the sample word.
- Sub-module frame_bank_ram: 2*N x WIDTH storage with one write port (bank, addr, data, we) and one registered read port (bank, addr). It has no reset on storage.
- Counters, bank pointers, full flags and overrun live in fft_sample_framer.

Test Plan:
- Frame fill, bit-reversed:
  - Stimulus: serially send samples 0x01..0x08, LSB first, en=1 continuously (64 cycles).
  - Response: frame_valid rises 1 cycle after the 8th word_strobe.
  - Reading rd_addr 0..7 gives rd_data 0x01,0x05,0x03,0x07,0x02,0x06,0x04,0x08, one cycle after each address.
- Gapped enable: same data with en toggling 1/0 every cycle.
  - Response: identical RAM contents and word_strobe count of 8; no overrun.
- Ping-pong:
  - Stimulus: fill bank0, then stream 0x11..0x18 without releasing.
  - Response: bank1 fills and frame_valid stays 1.
  - After frame_release, the next frame reads 0x11,0x15,0x13,0x17,0x12,0x16,0x14,0x18.
- Overrun:
  - Stimulus: fill both banks, then send a 17th sample 0xAA with no release.
  - Response: overrun=1 one cycle after capture and stays 1.
  - After two releases and a new frame, 0xAA appears nowhere.
- Spurious release: pulse frame_release while frame_valid=0.
  - Response: rb is unchanged; the next completed frame still reads from bank0.
- Reset mid-frame:
  - Stimulus: after 3 samples plus 4 bits, assert reset 1 cycle (shift register included), then send 0x01..0x08.
  - Response: clean frame as in the first test, overrun=0, frame_valid=0 during reset.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input framer.
//   FFT_WIDTH     : default sample width (equals the serial shift register width)
//   FFT_LOG2N     : default log2 of the frame length
//   FFT_MAX_LOG2N : widest index the bitrev helper supports
//   fft_word_t    : one sample word at the default width
//   bitrev()      : reverses the low log2n bits of a sample index
package fft_pkg;

    localparam int FFT_WIDTH     = 8;
    localparam int FFT_LOG2N     = 3;
    localparam int FFT_MAX_LOG2N = 16;

    typedef logic [FFT_WIDTH-1:0] fft_word_t;

    // Shift-based reversal keeps every bit select constant. Bit k of idx
    // lands at position log2n-1-k; bits at and above log2n come out as zero.
    function automatic logic [FFT_MAX_LOG2N-1:0] bitrev(
        input logic [FFT_MAX_LOG2N-1:0] idx,
        input int                       log2n
    );
        logic [FFT_MAX_LOG2N-1:0] r;
        logic [FFT_MAX_LOG2N-1:0] t;
        r = '0;
        t = idx;
        for (int i = 0; i < FFT_MAX_LOG2N; i++) begin
            if (i < log2n) begin
                r = {r[FFT_MAX_LOG2N-2:0], t[0]};
                t = t >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank sample store: 2*N words of WIDTH bits.
// The storage array has no reset. Only the read data register is cleared by reset.
//   clk, reset  : system clock and synchronous active-high reset (read register only)
//   i_we        : write enable
//   i_wr_bank   : bank to write
//   i_wr_addr   : word address within the write bank
//   i_wr_data   : word to write
//   i_rd_bank   : bank to read
//   i_rd_addr   : word address within the read bank
//   o_rd_data   : registered read data, one cycle after address
module frame_bank_ram
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH,
    parameter int LOG2N = FFT_LOG2N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic             i_wr_bank,
    input  logic [LOG2N-1:0] i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_bank,
    input  logic [LOG2N-1:0] i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    localparam int DEPTH = 2 * (2 ** LOG2N);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[{i_rd_bank, i_rd_addr}];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft_sample_framer.sv
// Frames serial-in shift register words into a ping-pong buffer for the FFT.
//   clk           : system clock
//   reset         : synchronous active-high, shared with the upstream shift register
//   en            : serial bit enable (same as the shift register's enable)
//   shift_word    : parallel word from the shift register
//   rd_addr       : FFT read address within the read bank
//   rd_data       : word at rd_addr in the read bank, one cycle later
//   frame_valid   : read bank holds a complete frame
//   frame_release : FFT has consumed the read bank
//   word_strobe   : pulses on every capture attempt (written or dropped)
//   overrun       : sticky, at least one sample dropped since reset
//
// Handshake: frame_valid stays high while the read bank is full. A one-cycle
// frame_release while frame_valid=1 frees that bank and moves the read pointer
// to the other bank at the same edge; frame_release while frame_valid=0 is ignored.
module fft_sample_framer
    import fft_pkg::*;
#(
    parameter int WIDTH  = FFT_WIDTH,
    parameter int LOG2N  = FFT_LOG2N,
    parameter bit BITREV = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] shift_word,
    input  logic [LOG2N-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             frame_valid,
    input  logic             frame_release,
    output logic             word_strobe,
    output logic             overrun
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    BIT_LAST  = CW'(WIDTH - 1);
    localparam logic [LOG2N-1:0] SAMP_LAST = LOG2N'((2 ** LOG2N) - 1);

    logic [CW-1:0]    r_bit_cnt;
    logic [LOG2N-1:0] r_samp_idx;
    logic             r_wb;
    logic             r_rb;
    logic [1:0]       r_full;
    logic             r_capture_pend;
    logic             r_overrun;

    logic             w_bit_last;
    logic             w_wr_ok;
    logic             w_drop;
    logic             w_samp_last;
    logic             w_release;
    logic [LOG2N-1:0] w_wr_addr;
    logic [1:0]       w_full_next;

    assign w_bit_last  = en && (r_bit_cnt == BIT_LAST);
    // The shift register loads the last bit on the same edge that sets
    // capture_pend, so the word is complete during the capture_pend cycle.
    assign w_wr_ok     = r_capture_pend && !r_full[r_wb];
    assign w_drop      = r_capture_pend &&  r_full[r_wb];
    assign w_samp_last = (r_samp_idx == SAMP_LAST);
    assign w_release   = frame_release && r_full[r_rb];
    assign w_wr_addr   = BITREV ? LOG2N'(bitrev(FFT_MAX_LOG2N'(r_samp_idx), LOG2N))
                                : r_samp_idx;

    // Release and completion can never target the same bank in one cycle:
    // completion needs that bank empty, release needs it full. A capture into
    // a bank being released sees the pre-edge full bit and is dropped.
    always_comb begin
        w_full_next = r_full;
        if (w_release) begin
            w_full_next[r_rb] = 1'b0;
        end
        if (w_wr_ok && w_samp_last) begin
            w_full_next[r_wb] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt      <= '0;
            r_samp_idx     <= '0;
            r_wb           <= 1'b0;
            r_rb           <= 1'b0;
            r_full         <= 2'b00;
            r_capture_pend <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            if (en) begin
                r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + 1'b1;
            end
            r_capture_pend <= w_bit_last;
            if (w_wr_ok) begin
                r_samp_idx <= w_samp_last ? '0 : r_samp_idx + 1'b1;
                if (w_samp_last) begin
                    r_wb <= ~r_wb;
                end
            end
            if (w_release) begin
                r_rb <= ~r_rb;
            end
            r_full <= w_full_next;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    frame_bank_ram #(
        .WIDTH (WIDTH),
        .LOG2N (LOG2N)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_wr_ok),
        .i_wr_bank (r_wb),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (shift_word),
        .i_rd_bank (r_rb),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    assign frame_valid = r_full[r_rb];
    assign word_strobe = r_capture_pend;
    assign overrun     = r_overrun;

endmodule
